// File: rtl/ctrl_pipe_regs.sv
// Control-signal pipeline after the decoder: per-stage stall, flush,
// valid and bit mask, with back-pressure and automatic bubbles.
module ctrl_pipe_regs #(
  parameter int W = 17,
  parameter int STAGES = 3,
  parameter logic [STAGES*W-1:0] MASK = {(STAGES*W){1'b1}},
  parameter logic [W-1:0] BUBBLE = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [W-1:0]        in_ctrl,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [STAGES-1:0]   stall,
  input  logic [STAGES-1:0]   flush,
  output logic [STAGES*W-1:0] stage_ctrl,
  output logic [STAGES-1:0]   stage_valid,
  output logic [3:0]          inflight
);

  logic [STAGES*W-1:0] ctrl_d, ctrl_q;
  logic [STAGES-1:0]   valid_d, valid_q;
  logic [STAGES-1:0]   hold;

  // A stall freezes its own stage and everything upstream of it.
  always_comb begin
    hold = '0;
    hold[STAGES-1] = stall[STAGES-1];
    for (int k = STAGES - 2; k >= 0; k--) begin
      hold[k] = stall[k] | hold[k+1];
    end
  end

  assign in_ready = ~hold[0];

  always_comb begin
    int p;
    logic [W-1:0] mk;
    logic [W-1:0] src_c;
    logic         src_v;
    logic         up_stall;
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    p = 0;
    mk = '0;
    src_c = '0;
    src_v = 1'b0;
    up_stall = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      p  = (k == 0) ? 0 : k - 1;
      mk = MASK[k*W +: W];
      if (k == 0) begin
        src_c = in_valid ? in_ctrl : BUBBLE;
        src_v = in_valid;
        up_stall = 1'b0;
      end else begin
        src_c = ctrl_q[p*W +: W];
        src_v = valid_q[p];
        up_stall = stall[p];
      end
      if (flush[k]) begin
        ctrl_d[k*W +: W] = BUBBLE & mk;
        valid_d[k] = 1'b0;
      end else if (hold[k]) begin
        ctrl_d[k*W +: W] = ctrl_q[k*W +: W];
        valid_d[k] = valid_q[k];
      end else if (up_stall) begin
        ctrl_d[k*W +: W] = BUBBLE & mk;
        valid_d[k] = 1'b0;
      end else begin
        ctrl_d[k*W +: W] = src_c & mk;
        valid_d[k] = src_v;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      valid_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    inflight = '0;
    for (int k = 0; k < STAGES; k++) begin
      inflight = inflight + {3'b000, valid_q[k]};
    end
  end

  assign stage_ctrl  = ctrl_q;
  assign stage_valid = valid_q;

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Bench for ctrl_pipe_regs: directed scenarios plus random traffic,
// checked every cycle against a stage-array reference model.
module tb_ctrl_pipe_regs;
  localparam int W = 17;
  localparam int S = 3;
  localparam logic [S*W-1:0] MASK_M = {17'h00003, {(2*W){1'b1}}};
  localparam logic [W-1:0] BUB_M = 17'h0A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] in_ctrl = '0;
  logic in_valid = 1'b0;
  logic [S-1:0] stall = '0;
  logic [S-1:0] flush = '0;

  logic rdy0, rdy1;
  logic [S*W-1:0] sc0, sc1;
  logic [S-1:0] sv0, sv1;
  logic [3:0] inf0, inf1;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ctrl_pipe_regs dut (
    .clk(clk), .rst(rst), .in_ctrl(in_ctrl), .in_valid(in_valid),
    .in_ready(rdy0), .stall(stall), .flush(flush),
    .stage_ctrl(sc0), .stage_valid(sv0), .inflight(inf0)
  );

  ctrl_pipe_regs #(.W(W), .STAGES(S), .MASK(MASK_M), .BUBBLE(BUB_M)) dut_m (
    .clk(clk), .rst(rst), .in_ctrl(in_ctrl), .in_valid(in_valid),
    .in_ready(rdy1), .stall(stall), .flush(flush),
    .stage_ctrl(sc1), .stage_valid(sv1), .inflight(inf1)
  );

  // Reference model: per instance, an array of stage contents.
  logic [W-1:0] m_ctrl [2][S];
  logic         m_valid[2][S];
  logic [W-1:0] m_mask [2][S];
  logic [W-1:0] m_bub  [2];

  initial begin
    for (int k = 0; k < S; k++) begin
      m_mask[0][k] = '1;
      m_mask[1][k] = MASK_M[k*W +: W];
      m_ctrl[0][k] = '0; m_ctrl[1][k] = '0;
      m_valid[0][k] = 1'b0; m_valid[1][k] = 1'b0;
    end
    m_bub[0] = '0;
    m_bub[1] = BUB_M;
  end

  always @(posedge clk) begin
    logic [S:0] st_up;
    logic frozen;
    st_up = {stall, 1'b0};
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < S; k++) begin
        frozen = 1'b0;
        for (int j = k; j < S; j++) if (stall[j]) frozen = 1'b1;
        if (rst) begin
          m_ctrl[i][k] <= '0; m_valid[i][k] <= 1'b0;
        end else if (flush[k]) begin
          m_ctrl[i][k] <= m_bub[i] & m_mask[i][k];
          m_valid[i][k] <= 1'b0;
        end else if (frozen) begin
          m_ctrl[i][k] <= m_ctrl[i][k];
        end else if (k == 0) begin
          m_ctrl[i][k] <= (in_valid ? in_ctrl : m_bub[i]) & m_mask[i][k];
          m_valid[i][k] <= in_valid;
        end else if (st_up[k]) begin
          m_ctrl[i][k] <= m_bub[i] & m_mask[i][k];
          m_valid[i][k] <= 1'b0;
        end else begin
          m_ctrl[i][k] <= m_ctrl[i][k-1] & m_mask[i][k];
          m_valid[i][k] <= m_valid[i][k-1];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input logic [S*W-1:0] sc,
                          input logic [S-1:0] sv, input logic [3:0] inf,
                          input logic rdy);
    int cnt;
    cnt = 0;
    for (int k = 0; k < S; k++) begin
      chk($sformatf("inst%0d ctrl%0d", i, k), 32'(sc[k*W +: W]),
          32'(m_ctrl[i][k]));
      chk($sformatf("inst%0d valid%0d", i, k), 32'(sv[k]),
          32'(m_valid[i][k]));
      if (m_valid[i][k]) cnt++;
    end
    chk($sformatf("inst%0d inflight", i), 32'(inf), 32'(cnt));
    chk($sformatf("inst%0d in_ready", i), 32'(rdy), 32'(stall == '0));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, sc0, sv0, inf0, rdy0);
      cmp_inst(1, sc1, sv1, inf1, rdy1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    repeat (S + 1) tick();
  endtask

  initial begin
    in_valid = 1'b1;
    in_ctrl = 17'h1FFFF;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst sc", 32'(sc0), 32'h0);
    chk("rst sv", 32'(sv0), 32'h0);
    chk("rst inflight", 32'(inf0), 32'h0);
    rst = 1'b0;
    tick();
    chk("post-rst s0", 32'(sc0[0 +: W]), 32'h1FFFF);
    chk("post-rst v0", 32'(sv0[0]), 32'h1);
    in_valid = 1'b0;
    tick();
    chk("mask s1", 32'(sc1[W +: W]), 32'h1FFFF);
    tick();
    chk("mask s2", 32'(sc1[2*W +: W]), 32'h00003);
    chk("nomask s2", 32'(sc0[2*W +: W]), 32'h1FFFF);
    tick();
    chk("drained", 32'(inf0), 32'h0);

    in_valid = 1'b1; in_ctrl = 17'h0ABCD;
    tick();
    chk("flow s0", 32'(sc0[0 +: W]), 32'h0ABCD);
    chk("flow v1", 32'(sv0[1]), 32'h0);
    chk("flow inf a", 32'(inf0), 32'h1);
    in_valid = 1'b0;
    tick();
    chk("flow s1", 32'(sc0[W +: W]), 32'h0ABCD);
    chk("flow s0 bubble", 32'(sc0[0 +: W]), 32'h0);
    tick();
    chk("flow s2", 32'(sc0[2*W +: W]), 32'h0ABCD);
    chk("flow inf c", 32'(inf0), 32'h1);
    tick();
    chk("flow inf d", 32'(inf0), 32'h0);

    in_valid = 1'b1; in_ctrl = 17'h0000A;
    tick();
    in_ctrl = 17'h0000B;
    tick();
    in_ctrl = 17'h0000C;
    stall = 3'b010;
    #1;
    chk("stall ready", 32'(rdy0), 32'h0);
    repeat (2) begin
      tick();
      chk("stall s1", 32'(sc0[W +: W]), 32'h0000A);
      chk("stall s0", 32'(sc0[0 +: W]), 32'h0000B);
      chk("stall s2", 32'(sc0[2*W +: W]), 32'h0);
      chk("stall v2", 32'(sv0[2]), 32'h0);
    end
    stall = '0;
    tick();
    chk("rel s2", 32'(sc0[2*W +: W]), 32'h0000A);
    chk("rel s1", 32'(sc0[W +: W]), 32'h0000B);
    chk("rel s0", 32'(sc0[0 +: W]), 32'h0000C);
    drain();

    in_valid = 1'b1; in_ctrl = 17'h00011;
    tick();
    chk("fl s0", 32'(sc0[0 +: W]), 32'h00011);
    in_ctrl = 17'h00022;
    stall = 3'b001; flush = 3'b001;
    #1;
    chk("fl ready", 32'(rdy0), 32'h0);
    tick();
    chk("fl s0 ctrl", 32'(sc0[0 +: W]), 32'h0);
    chk("fl s0 valid", 32'(sv0[0]), 32'h0);
    chk("fl s1 valid", 32'(sv0[1]), 32'h0);
    stall = '0; flush = '0;
    tick();
    chk("fl accept", 32'(sc0[0 +: W]), 32'h00022);
    chk("fl accept v", 32'(sv0[0]), 32'h1);
    drain();

    in_valid = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      in_ctrl = W'(n);
      tick();
    end
    chk("full inflight", 32'(inf0), 32'h3);
    stall = 3'b100; flush = 3'b010; rst = 1'b1;
    tick();
    chk("midrst sc", 32'(sc0), 32'h0);
    chk("midrst sv", 32'(sv0), 32'h0);
    chk("midrst inf", 32'(inf0), 32'h0);
    rst = 1'b0; stall = '0; flush = '0;

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(127) == 0);
      in_valid = $urandom_range(1);
      in_ctrl = W'($urandom());
      for (int k = 0; k < S; k++) begin
        stall[k] = ($urandom_range(4) == 0);
        flush[k] = ($urandom_range(9) == 0);
      end
      tick();
    end
    rst = 1'b0; stall = '0; flush = '0;
    drain();
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
